// File: rtl/core_id_scoreboard_pkg.sv
// Shared sizes and types for the ID-stage register scoreboard.
package core_id_scoreboard_pkg;

    localparam int CORE_RFIDX_WIDTH  = 5;
    localparam int CORE_SB_CNT_WIDTH = 2;
    localparam int NUM_REGS          = 1 << CORE_RFIDX_WIDTH;

    typedef logic [CORE_RFIDX_WIDTH-1:0] rfidx_t;

endpackage

// File: rtl/core_id_scoreboard_if.sv
// Issue-candidate, writeback and kill signals plus the hazard outputs of the scoreboard.
interface core_id_scoreboard_if;
    import core_id_scoreboard_pkg::*;

    logic   iss_rs1_ren;
    logic   iss_rs2_ren;
    rfidx_t iss_rs1_idx;
    rfidx_t iss_rs2_idx;
    logic   iss_rd_wen;
    rfidx_t iss_rd_idx;
    logic   iss_fire;
    logic   wb_valid;
    rfidx_t wb_rd_idx;
    logic   kill_valid;
    rfidx_t kill_rd_idx;
    logic   stall;
    logic   rs1_busy;
    logic   rs2_busy;
    logic   any_pending;
    logic   err;

    modport slave (
        input  iss_rs1_ren, iss_rs2_ren, iss_rs1_idx, iss_rs2_idx,
        input  iss_rd_wen, iss_rd_idx, iss_fire,
        input  wb_valid, wb_rd_idx, kill_valid, kill_rd_idx,
        output stall, rs1_busy, rs2_busy, any_pending, err
    );

    modport master (
        output iss_rs1_ren, iss_rs2_ren, iss_rs1_idx, iss_rs2_idx,
        output iss_rd_wen, iss_rd_idx, iss_fire,
        output wb_valid, wb_rd_idx, kill_valid, kill_rd_idx,
        input  stall, rs1_busy, rs2_busy, any_pending, err
    );

endinterface

// File: rtl/core_sb_cnt.sv
// One saturating outstanding-write counter; applies +1/-1/-2 net deltas per cycle
// and flags the cycle when the result had to be clamped.
module core_sb_cnt
    import core_id_scoreboard_pkg::*;
#(
    parameter int CNT_W = CORE_SB_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_wb_i,
    input  logic             dec_kill_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o,
    output logic             unf_o
);
    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = $signed({2'b00, {CNT_W{1'b1}}});

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [SUM_W-1:0] net_s;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1]) return '0;
        if (v > MAX_S)  return '1;
        return v[CNT_W-1:0];
    endfunction

    always_comb begin
        net_s = $signed({2'b00, cnt_q})
              + $signed({{(SUM_W-1){1'b0}}, inc_i})
              - $signed({{(SUM_W-1){1'b0}}, dec_wb_i})
              - $signed({{(SUM_W-1){1'b0}}, dec_kill_i});
        ovf_o = (net_s > MAX_S);
        unf_o = net_s[SUM_W-1];
        cnt_d = sat_cnt(net_s);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/core_id_scoreboard.sv
// ID-stage register scoreboard: per-register outstanding-write counters and the
// combinational RAW/WAW stall decision for the current issue candidate.
module core_id_scoreboard
    import core_id_scoreboard_pkg::*;
#(
    parameter int CNT_W     = CORE_SB_CNT_WIDTH,
    parameter int WB_BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    core_id_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] ovf, unf, nz;
    logic                err_q, err_d;
    logic                rs1_busy, rs2_busy, waw_full, stall;

    // x0 is hardwired to zero and never tracked.
    assign cnt[0] = '0;
    assign ovf[0] = 1'b0;
    assign unf[0] = 1'b0;
    assign nz[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        localparam rfidx_t RIDX = rfidx_t'(r);
        core_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc_i      (sb.iss_fire & sb.iss_rd_wen & (sb.iss_rd_idx == RIDX)),
            .dec_wb_i   (sb.wb_valid & (sb.wb_rd_idx == RIDX)),
            .dec_kill_i (sb.kill_valid & (sb.kill_rd_idx == RIDX)),
            .cnt_o      (cnt[r]),
            .ovf_o      (ovf[r]),
            .unf_o      (unf[r])
        );
        assign nz[r] = |cnt[r];
    end

    // A writeback retiring the last pending write releases the source this cycle; kill never does.
    function automatic logic src_busy(input logic ren, input rfidx_t idx,
                                      input logic [CNT_W-1:0] c, input logic wb_hit);
        return ren && (idx != '0) && (c != '0)
            && !((WB_BYPASS != 0) && wb_hit && (c == CNT_ONE));
    endfunction

    assign rs1_busy = src_busy(sb.iss_rs1_ren, sb.iss_rs1_idx, cnt[sb.iss_rs1_idx],
                               sb.wb_valid && (sb.wb_rd_idx == sb.iss_rs1_idx));
    assign rs2_busy = src_busy(sb.iss_rs2_ren, sb.iss_rs2_idx, cnt[sb.iss_rs2_idx],
                               sb.wb_valid && (sb.wb_rd_idx == sb.iss_rs2_idx));
    assign waw_full = sb.iss_rd_wen && (sb.iss_rd_idx != '0) && (cnt[sb.iss_rd_idx] == '1);
    assign stall    = rs1_busy | rs2_busy | waw_full;

    always_comb begin
        err_d = err_q | (|ovf) | (|unf) | (sb.iss_fire & stall);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign sb.stall       = stall;
    assign sb.rs1_busy    = rs1_busy;
    assign sb.rs2_busy    = rs2_busy;
    assign sb.any_pending = |nz;
    assign sb.err         = err_q;

endmodule

// File: tb/tb_core_id_scoreboard.sv
// Bench for core_id_scoreboard: two instances (writeback bypass on/off) fed the same
// directed stimulus, checked every cycle against a count-per-register model.
module tb_core_id_scoreboard;
    import core_id_scoreboard_pkg::*;

    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_id_scoreboard_if sb1 ();
    core_id_scoreboard_if sb0 ();

    core_id_scoreboard #(.CNT_W(CW), .WB_BYPASS(1)) dut1 (.clk(clk), .rst(rst), .sb(sb1.slave));
    core_id_scoreboard #(.CNT_W(CW), .WB_BYPASS(0)) dut0 (.clk(clk), .rst(rst), .sb(sb0.slave));

    assign sb0.iss_rs1_ren = sb1.iss_rs1_ren;
    assign sb0.iss_rs2_ren = sb1.iss_rs2_ren;
    assign sb0.iss_rs1_idx = sb1.iss_rs1_idx;
    assign sb0.iss_rs2_idx = sb1.iss_rs2_idx;
    assign sb0.iss_rd_wen  = sb1.iss_rd_wen;
    assign sb0.iss_rd_idx  = sb1.iss_rd_idx;
    assign sb0.iss_fire    = sb1.iss_fire;
    assign sb0.wb_valid    = sb1.wb_valid;
    assign sb0.wb_rd_idx   = sb1.wb_rd_idx;
    assign sb0.kill_valid  = sb1.kill_valid;
    assign sb0.kill_rd_idx = sb1.kill_rd_idx;

    // Model state: pending-write count per register, sticky error per instance (index = bypass).
    int cnt_m [32];
    bit err_m [2];
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic int eff(int idx, bit byp);
        int e;
        e = cnt_m[idx];
        if (byp && sb1.wb_valid && int'(sb1.wb_rd_idx) == idx && e > 0) e = e - 1;
        return e;
    endfunction

    function automatic bit m_busy(bit ren, int idx, bit byp);
        return ren && idx != 0 && eff(idx, byp) != 0;
    endfunction

    function automatic bit m_stall(bit byp);
        return m_busy(sb1.iss_rs1_ren, int'(sb1.iss_rs1_idx), byp)
            || m_busy(sb1.iss_rs2_ren, int'(sb1.iss_rs2_idx), byp)
            || (sb1.iss_rd_wen && sb1.iss_rd_idx != 0 && cnt_m[int'(sb1.iss_rd_idx)] == MAXC);
    endfunction

    function automatic bit m_pending();
        for (int r = 1; r < 32; r++) if (cnt_m[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt_m[r] <= 0;
            err_m[0] <= 1'b0;
            err_m[1] <= 1'b0;
        end else begin
            bit sat;
            sat = 1'b0;
            for (int r = 1; r < 32; r++) begin
                int n;
                n = cnt_m[r];
                if (sb1.iss_fire && sb1.iss_rd_wen && int'(sb1.iss_rd_idx) == r) n = n + 1;
                if (sb1.wb_valid && int'(sb1.wb_rd_idx) == r) n = n - 1;
                if (sb1.kill_valid && int'(sb1.kill_rd_idx) == r) n = n - 1;
                if (n < 0)    begin n = 0;    sat = 1'b1; end
                if (n > MAXC) begin n = MAXC; sat = 1'b1; end
                cnt_m[r] <= n;
            end
            err_m[0] <= err_m[0] | sat | (sb1.iss_fire & m_stall(1'b0));
            err_m[1] <= err_m[1] | sat | (sb1.iss_fire & m_stall(1'b1));
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_byp1",  int'(sb1.stall),       int'(m_stall(1'b1)));
            chk("rs1_byp1",    int'(sb1.rs1_busy),    int'(m_busy(sb1.iss_rs1_ren, int'(sb1.iss_rs1_idx), 1'b1)));
            chk("rs2_byp1",    int'(sb1.rs2_busy),    int'(m_busy(sb1.iss_rs2_ren, int'(sb1.iss_rs2_idx), 1'b1)));
            chk("pend_byp1",   int'(sb1.any_pending), int'(m_pending()));
            chk("err_byp1",    int'(sb1.err),         int'(err_m[1]));
            chk("stall_byp0",  int'(sb0.stall),       int'(m_stall(1'b0)));
            chk("rs1_byp0",    int'(sb0.rs1_busy),    int'(m_busy(sb1.iss_rs1_ren, int'(sb1.iss_rs1_idx), 1'b0)));
            chk("rs2_byp0",    int'(sb0.rs2_busy),    int'(m_busy(sb1.iss_rs2_ren, int'(sb1.iss_rs2_idx), 1'b0)));
            chk("pend_byp0",   int'(sb0.any_pending), int'(m_pending()));
            chk("err_byp0",    int'(sb0.err),         int'(err_m[0]));
        end
    end

    task automatic idle();
        sb1.iss_rs1_ren = 1'b0; sb1.iss_rs1_idx = '0;
        sb1.iss_rs2_ren = 1'b0; sb1.iss_rs2_idx = '0;
        sb1.iss_rd_wen  = 1'b0; sb1.iss_rd_idx  = '0;
        sb1.iss_fire    = 1'b0;
        sb1.wb_valid    = 1'b0; sb1.wb_rd_idx   = '0;
        sb1.kill_valid  = 1'b0; sb1.kill_rd_idx = '0;
    endtask

    // Advance one clock; inputs return to idle 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(int rd);
        sb1.iss_rd_wen = 1'b1; sb1.iss_rd_idx = rfidx_t'(rd); sb1.iss_fire = 1'b1;
    endtask

    task automatic wb(int rd);
        sb1.wb_valid = 1'b1; sb1.wb_rd_idx = rfidx_t'(rd);
    endtask

    task automatic src1(int rs);
        sb1.iss_rs1_ren = 1'b1; sb1.iss_rs1_idx = rfidx_t'(rs);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_stall", int'(sb1.stall), 0);
        chk("rst_pend",  int'(sb1.any_pending), 0);
        chk("rst_err",   int'(sb1.err), 0);

        // RAW on x5, released by same-cycle writeback only with bypass
        tick(); issue(5);
        tick(); src1(5);
        #1;
        chk("raw_stall",    int'(sb1.stall), 1);
        chk("raw_rs1busy",  int'(sb1.rs1_busy), 1);
        chk("raw_mcnt5",    cnt_m[5], 1);
        wb(5);
        #1;
        chk("byp_stall1",   int'(sb1.stall), 0);
        chk("byp_stall0",   int'(sb0.stall), 1);

        // WAW saturation on x7
        tick(); issue(7);
        tick(); issue(7);
        tick(); issue(7);
        tick(); sb1.iss_rd_wen = 1'b1; sb1.iss_rd_idx = 5'd7;
        #1;
        chk("waw_stall",    int'(sb1.stall), 1);
        chk("waw_mcnt7",    cnt_m[7], 3);
        tick(); wb(7);
        tick(); sb1.iss_rd_wen = 1'b1; sb1.iss_rd_idx = 5'd7;
        #1;
        chk("waw_release",  int'(sb1.stall), 0);
        chk("waw_mcnt7b",   cnt_m[7], 2);
        tick(); wb(7);
        tick(); wb(7);

        // issue + wb same register in one cycle leaves the count unchanged
        tick(); issue(3);
        tick(); issue(3); wb(3);
        tick(); src1(3);
        #1;
        chk("net_rs1busy",  int'(sb1.rs1_busy), 1);
        chk("net_mcnt3",    cnt_m[3], 1);
        tick(); wb(3);
        tick();
        #1;
        chk("drain_pend",   int'(sb1.any_pending), 0);

        // x0 never tracked
        tick(); issue(0); src1(0); sb1.iss_rs2_ren = 1'b1; sb1.iss_rs2_idx = '0;
        #1;
        chk("x0_busy",      int'(sb1.rs1_busy), 0);
        chk("x0_stall",     int'(sb1.stall), 0);
        tick();
        #1;
        chk("x0_pend",      int'(sb1.any_pending), 0);

        // underflow on x9 sets a sticky error
        tick(); wb(9);
        tick();
        #1;
        chk("unf_err",      int'(sb1.err), 1);
        chk("unf_mcnt9",    cnt_m[9], 0);
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("unf_sticky",   int'(sb0.err), 1);

        // reset wins over pending writes and same-cycle events
        tick(); issue(4);
        tick(); issue(6);
        tick(); issue(8); wb(4); rst = 1'b1;
        tick(); rst = 1'b0; src1(4);
        #1;
        chk("rst2_pend",    int'(sb1.any_pending), 0);
        chk("rst2_err",     int'(sb1.err), 0);
        chk("rst2_busy",    int'(sb1.rs1_busy), 0);
        chk("rst2_mcnt8",   cnt_m[8], 0);

        // firing on a bypassed source: protocol error only without bypass
        tick(); issue(12);
        tick(); src1(12); wb(12); sb1.iss_fire = 1'b1;
        tick();
        #1;
        chk("fire_err1",    int'(sb1.err), 0);
        chk("fire_err0",    int'(sb0.err), 1);

        // wb + kill on the same register retire two writes at once
        tick(); issue(10);
        tick(); issue(10);
        tick(); wb(10); sb1.kill_valid = 1'b1; sb1.kill_rd_idx = 5'd10;
        tick();
        #1;
        chk("kill_mcnt10",  cnt_m[10], 0);
        chk("kill_pend",    int'(sb1.any_pending), 0);

        // overflow on x11 with rs2 hazard observation
        for (int i = 0; i < 4; i++) begin
            tick(); issue(11);
        end
        tick(); sb1.iss_rs2_ren = 1'b1; sb1.iss_rs2_idx = 5'd11;
        #1;
        chk("ovf_rs2busy",  int'(sb1.rs2_busy), 1);
        chk("ovf_err",      int'(sb1.err), 1);
        chk("ovf_mcnt11",   cnt_m[11], 3);
        tick();
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_id_scoreboard.md
CORE_ID_SCOREBOARD -- requirements
Module: core_id_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of each per-register outstanding-write counter (max count 2^CNT_W-1).
REQ-002 SHALL have parameter WB_BYPASS, default 1; 1 = a same-cycle writeback that retires the last pending write clears busy in that same cycle.
REQ-003 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports iss_rs1_ren/iss_rs2_ren  in  1  candidate instruction reads rs1/rs2; iss_rs1_idx/iss_rs2_idx  in  CORE_RFIDX_WIDTH  source indices.
REQ-006 SHALL have ports iss_rd_wen  in  1  candidate writes rd; iss_rd_idx  in  CORE_RFIDX_WIDTH  destination index.
REQ-007 SHALL have port iss_fire  in  1  candidate accepted by EXU this cycle (valid & ready of the ID->EX handshake).
REQ-008 SHALL have ports wb_valid  in  1 and wb_rd_idx  in  CORE_RFIDX_WIDTH  register-file write retiring one pending write.
REQ-009 SHALL have ports kill_valid  in  1 and kill_rd_idx  in  CORE_RFIDX_WIDTH  issued writer squashed after issue (e.g. branch mispredict in EX); retires one pending write without a register write.
REQ-010 SHALL have ports stall  out  1  candidate must not issue; rs1_busy/rs2_busy  out  1  per-source hazard; any_pending  out  1  some counter non-zero; err  out  1  sticky protocol error.

Function
REQ-011 SHALL keep one CNT_W-bit counter per register 1..31; x0 is never tracked, always reads count 0.
REQ-012 SHALL increment cnt[iss_rd_idx] when iss_fire & iss_rd_wen & iss_rd_idx!=0.
REQ-013 SHALL decrement cnt[wb_rd_idx] when wb_valid & wb_rd_idx!=0, and cnt[kill_rd_idx] when kill_valid & kill_rd_idx!=0.
REQ-014 SHALL apply all events in one cycle to the same register as a net delta (issue +1, wb -1, kill -1); issue+wb same reg = unchanged; wb+kill same reg = -2.
REQ-015 SHALL saturate: net result below 0 clamps to 0 and sets err; above 2^CNT_W-1 clamps to max and sets err.
REQ-016 SHALL compute rsN_busy = iss_rsN_ren & idx!=0 & eff_cnt[idx]!=0, purely combinational from current state and inputs (zero-cycle).
REQ-017 SHALL use eff_cnt = cnt minus same-cycle wb decrement when WB_BYPASS=1, else eff_cnt = cnt; kill never bypasses.
REQ-018 SHALL assert stall = rs1_busy | rs2_busy | (iss_rd_wen & iss_rd_idx!=0 & cnt[iss_rd_idx]==max).
REQ-019 SHALL not gate counting on stall: iss_fire while stall is a protocol error, sets err, counter still updates per REQ-015.
REQ-020 SHALL keep err set until reset once set.
REQ-021 SHALL not clear counters on pipeline flush; flush of un-issued instructions needs no action, flushed issued writers arrive via kill.

Reset
REQ-022 SHALL on rst=1 at a clock edge clear all counters and err; outputs then: stall=0 for non-hazard inputs, rs1_busy=rs2_busy=0, any_pending=0, err=0.
REQ-023 SHALL give rst priority over same-cycle iss/wb/kill events (events discarded), including mid-operation with pending writes.

Structure
REQ-024 SHALL take CORE_RFIDX_WIDTH and a new CORE_SB_CNT_WIDTH default from the shared core_defines.v header.
REQ-025 SHALL factor one sub-module core_sb_cnt (single saturating up/down counter with +1/-1/-2 delta and overflow/underflow flags), instantiated 31 times.
REQ-026 SHALL use registered state only in counters and err; all other outputs combinational.

Verification
REQ-027 SHALL cover: issue rd=x5 (iss_fire, wen), next cycle candidate rs1=x5 -> stall=1, rs1_busy=1; wb x5 same cycle -> stall=0 (WB_BYPASS=1), stall=1 (WB_BYPASS=0).
REQ-028 SHALL cover: three issues to x7 then fourth candidate rd=x7 -> stall=1 by WAW saturation; one wb x7 -> stall=0, cnt=2.
REQ-029 SHALL cover: same-cycle issue rd=x3 and wb x3 with cnt=1 -> cnt stays 1, rs1=x3 busy next cycle.
REQ-030 SHALL cover: wb x9 with cnt=0 -> err=1, cnt stays 0; err remains 1 after 10 idle cycles, cleared only by rst.
REQ-031 SHALL cover: x0 as rd/rs with iss_fire -> no counter change, rs busy=0, any_pending=0.
REQ-032 SHALL cover: rst asserted while x4,x6 pending and iss_fire to x8 -> next cycle all counters 0, any_pending=0, err=0.
